// File: rtl/rsa_pkg.sv
// rsa_pkg: state/phase types and core register-select codes for rsa_ctrl
package rsa_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WR, S_START, S_WAIT_HI,
        S_WAIT_LO, S_RD_ADDR, S_RD_CAP, S_SEND, S_ERR
    } state_t;

    typedef enum logic [1:0] {PH_MOD, PH_BASE, PH_EXP} phase_t;

    localparam logic [1:0] SEL_RESULT = 2'd0;
    localparam logic [1:0] SEL_BASE   = 2'd1;
    localparam logic [1:0] SEL_EXP    = 2'd2;
    localparam logic [1:0] SEL_MOD    = 2'd3;

    function automatic logic [1:0] ph_sel(input phase_t ph);
        return ph == PH_MOD ? SEL_MOD : ph == PH_BASE ? SEL_BASE : SEL_EXP;
    endfunction

endpackage

// File: rtl/rsa_ctrl.sv
// rsa_ctrl: byte-stream sequencer that loads, starts and reads back the rsa core
module rsa_ctrl
    import rsa_pkg::*;
#(
    parameter int NBYTES  = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy,
    output logic       done,
    output logic       timeout_err,
    output logic       core_we_n,
    output logic       core_oe_n,
    output logic       core_start_n,
    output logic [1:0] core_reg_sel,
    output logic [5:0] core_addr,
    output logic [7:0] core_wdata,
    input  logic [7:0] core_rdata,
    input  logic       core_busy
);

    localparam int           TW   = $clog2(TIMEOUT + 1);
    localparam logic [5:0]   LAST = 6'(NBYTES - 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

    state_t        r_state, w_next;
    phase_t        r_ph;
    logic [5:0]    r_cnt;
    logic [7:0]    r_wdata, r_odata;
    logic          r_oval, r_done, r_err;
    logic [TW-1:0] r_tmr;
    logic          r_we_n, r_oe_n, r_start_n;
    logic [1:0]    r_sel;
    logic          w_last, w_tmo, w_we_n, w_oe_n, w_start_n;
    logic [1:0]    w_sel;

    assign w_last = r_cnt == LAST;
    assign w_tmo  = r_tmr >= TLIM;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // next-state decode; a busy edge wins over a coincident timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_LOAD: w_next = in_valid ? S_WR : r_state;
            S_WR:           w_next = (w_last && r_ph == PH_EXP) ? S_START : S_LOAD;
            S_START:        w_next = S_WAIT_HI;
            S_WAIT_HI:      w_next = core_busy ? S_WAIT_LO : w_tmo ? S_ERR : S_WAIT_HI;
            S_WAIT_LO:      w_next = !core_busy ? S_RD_ADDR : w_tmo ? S_ERR : S_WAIT_LO;
            S_RD_ADDR:      w_next = S_RD_CAP;
            S_RD_CAP:       w_next = S_SEND;
            S_SEND:         w_next = !out_ready ? S_SEND : w_last ? S_IDLE : S_RD_ADDR;
            default:        w_next = S_ERR;
        endcase
    end

    // outputs: handshake flags from the current state, core strobes for the state being entered
    always_comb begin
        in_ready  = r_state == S_IDLE || r_state == S_LOAD;
        busy      = r_state != S_IDLE;
        w_we_n    = w_next != S_WR;
        w_oe_n    = w_next != S_RD_ADDR;
        w_start_n = w_next != S_START;
        w_sel     = w_next != S_WR ? SEL_RESULT : r_state == S_IDLE ? SEL_MOD : ph_sel(r_ph);
    end

    // core strobes registered so the bus sees clean single-cycle pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_start_n <= 1'b1;
            r_sel     <= SEL_RESULT;
        end else begin
            r_we_n    <= w_we_n;
            r_oe_n    <= w_oe_n;
            r_start_n <= w_start_n;
            r_sel     <= w_sel;
        end
    end

    // operand/result datapath, byte and phase counters, timeout counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ph    <= PH_MOD;
            r_cnt   <= '0;
            r_wdata <= '0;
            r_odata <= '0;
            r_oval  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_tmr   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_wdata <= in_data;
                    r_ph    <= PH_MOD;
                    r_cnt   <= '0;
                end
                S_LOAD: if (in_valid) r_wdata <= in_data;
                S_WR: if (!w_last) r_cnt <= r_cnt + 1'b1;
                    else if (r_ph != PH_EXP) begin
                        r_ph  <= r_ph == PH_MOD ? PH_BASE : PH_EXP;
                        r_cnt <= '0;
                    end
                // the counter tracks cycles since the start pulse, so ERR lands on cycle TIMEOUT
                S_START: r_tmr <= TW'(1);
                S_WAIT_HI, S_WAIT_LO: begin
                    r_tmr <= r_tmr + 1'b1;
                    if (w_next == S_RD_ADDR) r_cnt <= '0;
                    if (w_next == S_ERR) r_err <= 1'b1;
                end
                S_RD_CAP: begin
                    r_odata <= core_rdata;
                    r_oval  <= 1'b1;
                end
                S_SEND: if (out_ready) begin
                    r_oval <= 1'b0;
                    if (w_last) r_done <= 1'b1;
                    else r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_valid    = r_oval;
    assign out_data     = r_odata;
    assign done         = r_done;
    assign timeout_err  = r_err;
    assign core_we_n    = r_we_n;
    assign core_oe_n    = r_oe_n;
    assign core_start_n = r_start_n;
    assign core_reg_sel = r_sel;
    assign core_addr    = r_cnt;
    assign core_wdata   = r_wdata;

endmodule

// File: doc/rsa_ctrl.md
# rsa_ctrl

Sequencer for the `rsa` modular-exponentiation core. It accepts a byte stream from the host: modulus, then base, then exponent. It writes each byte into the core's operand registers, fires a single start pulse and waits for the core's busy flag to rise and fall. It then reads the result back and streams it out, so the core sits behind one valid/ready byte interface instead of being driven directly from the board bus.

## Interface
Parameters:
- NBYTES, 32, operand/result length in bytes (1..64)
- TIMEOUT, 4096, max cycles from start pulse to core busy falling

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  host byte valid
- in_ready  out  1  controller accepts host byte
- in_data  in  8  host byte
- out_valid  out  1  result byte valid
- out_ready  in  1  downstream accepts result byte
- out_data  out  8  result byte, LSB byte first
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after last result byte handshake
- timeout_err  out  1  sticky, set on timeout, cleared only by reset
- core_we_n  out  1  core write strobe, active low
- core_oe_n  out  1  core read strobe, active low
- core_start_n  out  1  core start, active low
- core_reg_sel  out  2  core register select
- core_addr  out  6  core byte address
- core_wdata  out  8  byte to core data_i
- core_rdata  in  8  core data_o
- core_busy  in  1  core ready output, high while computing

## Operation
- States: IDLE, LOAD, WR, START, WAIT_HI, WAIT_LO, RD_ADDR, RD_CAP, SEND, ERR.
- Operand phase counter ph ∈ {MOD, BASE, EXP} maps to reg_sel 3, 1, 2. Byte counter cnt runs 0..NBYTES-1. core_addr = zero-extended cnt.
- IDLE: in_ready=1. The first in_valid handshake sets ph=MOD, cnt=0, and goes to WR with the byte registered.
- LOAD: in_ready=1. A handshake registers in_data into core_wdata and goes to WR.
- WR: core_we_n=0 for exactly one cycle with reg_sel/addr/wdata stable, and in_ready=0.
  - If cnt<NBYTES-1: cnt++ and go to LOAD.
  - Else if ph≠EXP: advance ph, cnt=0, go to LOAD.
  - Else go to START.
- START: core_start_n=0 for exactly one cycle. Clear the timeout counter. Go to WAIT_HI.
- WAIT_HI: wait for core_busy=1, then go to WAIT_LO.
- WAIT_LO: wait for core_busy=0, then set cnt=0 and go to RD_ADDR.
- The timeout counter runs through WAIT_HI and WAIT_LO. When it reaches TIMEOUT, go to ERR and set timeout_err.
- RD_ADDR: core_oe_n=0, reg_sel=0, addr=cnt for one cycle. The core registers data_o on this edge.
- RD_CAP: capture core_rdata into out_data and set out_valid=1. Go to SEND.
- SEND: hold out_data and out_valid until out_ready.
  - On handshake with cnt<NBYTES-1: cnt++, go to RD_ADDR.
  - On the last byte: pulse done, go to IDLE.
- ERR: all handshake outputs are 0 and core strobes are inactive. The block stays in ERR until reset.
- in_valid is ignored outside IDLE/LOAD. out_ready is ignored while out_valid=0.
- core_we_n and core_oe_n are never low in the same cycle. At most one strobe is active per cycle.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=1
  - out_valid=0, out_data=0
  - busy=0, done=0, timeout_err=0
  - core_we_n=1, core_oe_n=1, core_start_n=1
  - core_reg_sel=0, core_addr=0, core_wdata=0
- Reset asserted mid-operation returns to these values immediately. The next load restarts at MOD, addr 0.
- Load throughput: 2 cycles per byte at most. 3·NBYTES write strobes in total.
- The start pulse is issued 1 cycle after the last write strobe.
- Read throughput: 3 cycles per byte with out_ready held high. The RD_ADDR→RD_CAP latency is 1 cycle.
- All core_* outputs are registered, so no combinational path from in_* or out_ready reaches core_*.
- done rises in the cycle after the final out handshake. busy falls in the same cycle.

## Structure
- Package rsa_pkg holds:
  - the state enum
  - phase enum
  - constants SEL_RESULT=0, SEL_BASE=1, SEL_EXP=2, SEL_MOD=3
- Single module. No sub-module: the counters and FSM are inline.

## Test plan
- Reset, then idle 10 cycles: all outputs at reset values, no strobes.
- Send 96 bytes 0x00..0x5F: 96 core_we_n pulses.
  - reg_sel 3, addr 0..31, data 0x00..0x1F.
  - Then reg_sel 1, data 0x20..0x3F.
  - Then reg_sel 2, data 0x40..0x5F.
  - Then exactly one core_start_n low cycle.
- Core model raises busy 1 cycle after start and holds it 40 cycles: 32 oe reads, addr 0..31, reg_sel 0. out_data equals the model bytes. One done pulse.
- Hold out_ready low 5 cycles on result byte 3: out_data stable, out_valid high, no extra core_oe_n pulses.
- TIMEOUT=16, core_busy stuck low: timeout_err=1 and busy=1 at 16 cycles after start. in_ready=0 thereafter, no strobes.
- Assert reset after 40 loaded bytes: immediate reset values. A new 96-byte load starts at reg_sel 3, addr 0.
